// File: rtl/gmii_frame_check.sv
// GMII receive frame checker: preamble/SFD, CRC-32, length and rx_er
// validation; forwards payload with the 4 FCS bytes stripped.
module gmii_frame_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rxd,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [3:0]       err,
  output logic [10:0]      frame_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);

  state_t      state;
  state_t      state_nx;
  logic        prev_dv;
  logic        start;
  logic [4:0]  pre_cnt;
  logic [4:0]  cnt_nx;
  logic [4:0]  cnt_base;
  logic        pre_step;
  logic        sfd;
  logic        dbyte;
  logic        done;
  logic [3:0]  err_nx;
  logic        er_seen;
  logic        len_bad;
  logic [31:0] crc;
  logic [10:0] len;
  logic [7:0]  dly [4];
  logic [7:0]  hold;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign start   = rx_dv && !prev_dv;
  assign len_bad = (len < MIN_L) || (len > MAX_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_cnt <= 5'd0;
    end else begin
      state   <= state_nx;
      pre_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = pre_cnt;
    cnt_base = (state == IDLE) ? 5'd0 : pre_cnt;
    pre_step = 1'b0;
    sfd      = 1'b0;
    dbyte    = 1'b0;
    done     = 1'b0;
    err_nx   = 4'd0;
    unique case (state)
      IDLE:    pre_step = start;
      PRE:     pre_step = rx_dv;
      DATA:    dbyte    = rx_dv;
      DROP:    ;
      default: ;
    endcase
    // the start-edge byte is already the first preamble byte
    if (pre_step) begin
      unique case (1'b1)
        rxd == 8'h55: begin
          cnt_nx   = cnt_base + 5'd1;
          state_nx = (cnt_nx > 5'd15) ? DROP : PRE;
        end
        rxd == 8'hD5 && cnt_base != 5'd0: begin
          state_nx = DATA;
          sfd      = 1'b1;
        end
        default: state_nx = DROP;
      endcase
    end
    if (state != IDLE && !rx_dv) begin
      done     = 1'b1;
      state_nx = IDLE;
      if (state == DATA)
        err_nx = {er_seen, len_bad, crc != RESIDUE, 1'b0};
      else
        err_nx = {er_seen, 3'b001};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_dv    <= 1'b1;
      er_seen    <= 1'b0;
      crc        <= '1;
      len        <= 11'd0;
      for (int i = 0; i < 4; i++) dly[i] <= 8'd0;
      hold       <= 8'd0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err        <= 4'd0;
      frame_len  <= 11'd0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      prev_dv    <= rx_dv;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      if (start)
        er_seen <= rx_er;
      else if (state != IDLE && rx_dv)
        er_seen <= er_seen | rx_er;
      if (sfd) begin
        crc <= '1;
        len <= 11'd0;
      end
      if (dbyte) begin
        crc <= crc_byte(crc, rxd);
        if (len != 11'h7FF) len <= len + 11'd1;
        dly[0] <= rxd;
        for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
        hold <= dly[3];
        // hold is a real payload byte once five bytes are in
        if (len >= 11'd5) begin
          out_valid <= 1'b1;
          out_data  <= hold;
          out_first <= (len == 11'd5);
        end
      end
      if (done) begin
        frame_done <= 1'b1;
        frame_ok   <= (err_nx == 4'd0);
        err        <= err_nx;
        frame_len  <= (state == DATA) ? len : 11'd0;
        if (err_nx == 4'd0) good_cnt <= good_cnt + CNT_W'(1);
        else                bad_cnt  <= bad_cnt + CNT_W'(1);
        if (state == DATA && len >= 11'd5) begin
          out_valid <= 1'b1;
          out_data  <= hold;
          out_first <= (len == 11'd5);
          out_last  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_frame_check.sv
// Scoreboard bench for gmii_frame_check: directed frames, queued
// expectations, monitor pops on out_valid and frame_done.
module tb_gmii_frame_check;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rxd;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_first;
  logic        out_last;
  logic        frame_done;
  logic        frame_ok;
  logic [3:0]  err;
  logic [10:0] frame_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_frame_check #(
    .MIN_LEN(64),
    .MAX_LEN(1518),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .err       (err),
    .frame_len (frame_len),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  typedef struct {
    logic [3:0]  err;
    logic [10:0] len;
    logic [15:0] g;
    logic [15:0] b;
  } stat_t;

  logic [7:0]  fq [$];
  logic [9:0]  dq [$];
  stat_t       sq [$];
  int          tests;
  int          fails;
  logic [15:0] eg;
  logic [15:0] eb;

  initial clk = 1'b0;
  always #4 clk = ~clk;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic add_pre(input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'h55);
    fq.push_back(8'hD5);
  endtask

  task automatic add_body(input int n, input int flip,
                          input logic [7:0] base, input bit exp_on);
    logic [31:0] c;
    logic [7:0]  b;
    logic [7:0]  s;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      c = crc_upd(c, b);
      s = (i == flip) ? (b ^ 8'h01) : b;
      fq.push_back(s);
      if (exp_on) dq.push_back({i == 0, i == n - 1, s});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fq.push_back(c[8*k +: 8]);
  endtask

  task automatic exp_stat(input logic [3:0] e, input logic [10:0] l);
    stat_t s;
    if (e == 4'd0) eg = eg + 16'd1;
    else           eb = eb + 16'd1;
    s.err = e;
    s.len = l;
    s.g   = eg;
    s.b   = eb;
    sq.push_back(s);
  endtask

  task automatic drive(input int er_idx, input int extra);
    for (int i = 0; i < fq.size(); i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rxd   = fq[i];
      rx_er = (i == er_idx);
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 8'h00;
    repeat (extra) @(posedge clk);
    fq.delete();
  endtask

  task automatic monitor();
    logic [9:0] e;
    stat_t      s;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (dq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte got=%h exp=none", out_data);
          end else begin
            e = dq.pop_front();
            chk("out_byte", {54'd0, out_first, out_last, out_data},
                {54'd0, e});
          end
        end
        if (frame_done) begin
          if (sq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done got=err%h exp=none", err);
          end else begin
            s = sq.pop_front();
            chk("status",
                {12'd0, err, frame_ok, frame_len, good_cnt, bad_cnt},
                {12'd0, s.err, s.err == 4'd0, s.len, s.g, s.b});
          end
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    eg    = 16'd0;
    eb    = 16'd0;
    rst_n = 1'b0;
    rxd   = 8'h00;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_done", {63'd0, frame_done}, 64'd0);
    chk("rst_stat", {24'd0, err, frame_len, frame_ok, out_data},
        64'd0);
    chk("rst_cnt", {32'd0, good_cnt, bad_cnt}, 64'd0);
    // good 64-byte frame
    add_pre(7);
    add_body(60, -1, 8'h00, 1'b1);
    exp_stat(4'b0000, 11'd64);
    drive(-1, 10);
    // payload byte 10 corrupted
    add_pre(7);
    add_body(60, 10, 8'h00, 1'b1);
    exp_stat(4'b0010, 11'd64);
    drive(-1, 10);
    // bad preamble byte
    fq = '{8'h55, 8'h55, 8'h54, 8'hD5};
    for (int i = 0; i < 10; i++) fq.push_back(8'hA0 + 8'(i));
    exp_stat(4'b0001, 11'd0);
    drive(-1, 10);
    // rx_er for one cycle mid-payload
    add_pre(7);
    add_body(60, -1, 8'h00, 1'b1);
    exp_stat(4'b1000, 11'd64);
    drive(38, 10);
    // runt with valid FCS
    add_pre(7);
    add_body(16, -1, 8'h40, 1'b1);
    exp_stat(4'b0100, 11'd20);
    drive(-1, 10);
    // back-to-back, one idle byte
    add_pre(7);
    add_body(60, -1, 8'h10, 1'b1);
    exp_stat(4'b0000, 11'd64);
    drive(-1, 0);
    add_pre(7);
    add_body(60, -1, 8'h80, 1'b1);
    exp_stat(4'b0000, 11'd64);
    drive(-1, 10);
    // N=5: single payload byte, first and last together
    add_pre(7);
    add_body(1, -1, 8'hC3, 1'b1);
    exp_stat(4'b0100, 11'd5);
    drive(-1, 10);
    // N=3: no payload, CRC and length bad
    add_pre(7);
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    fq.push_back(8'hCC);
    exp_stat(4'b0110, 11'd3);
    drive(-1, 10);
    // 15 preamble bytes still legal
    add_pre(15);
    add_body(60, -1, 8'h20, 1'b1);
    exp_stat(4'b0000, 11'd64);
    drive(-1, 10);
    // 16 preamble bytes rejected
    add_pre(16);
    add_body(60, -1, 8'h20, 1'b0);
    exp_stat(4'b0001, 11'd0);
    drive(-1, 10);
    // reset mid-payload, released while rx_dv high
    add_pre(7);
    add_body(60, -1, 8'h00, 1'b0);
    for (int i = 0; i < 15; i++)
      dq.push_back({i == 0, 1'b0, 8'(i)});
    for (int i = 0; i < fq.size(); i++) begin
      @(posedge clk); #1;
      rx_dv = 1'b1;
      rxd   = fq[i];
      rx_er = 1'b0;
      if (i == 28) begin
        @(negedge clk); #1;
        rst_n = 1'b0;
        eg    = 16'd0;
        eb    = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    rx_dv = 1'b0;
    rxd   = 8'h00;
    repeat (10) @(posedge clk);
    fq.delete();
    add_pre(7);
    add_body(60, -1, 8'h05, 1'b1);
    exp_stat(4'b0000, 11'd64);
    drive(-1, 20);
    chk("data_left", 64'(dq.size()), 64'd0);
    chk("stat_left", 64'(sq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
